// File: rtl/motion_sequencer_if.sv
// Signal bundle between the motion sequencer and its game-side peers.
// The master drives frame/key/collision inputs; the slave is the sequencer.
interface motion_sequencer_if;
    logic       startOfFrame;
    logic       startKey;
    logic       pauseKey;
    logic       collision;
    logic       bottomHit;
    logic       moveFrame;
    logic       X_direction;
    logic       toggleY;
    logic       moverResetN;
    logic [1:0] lives;
    logic [2:0] state;

    modport master (
        output startOfFrame, startKey, pauseKey, collision, bottomHit,
        input  moveFrame, X_direction, toggleY, moverResetN, lives, state
    );

    modport slave (
        input  startOfFrame, startKey, pauseKey, collision, bottomHit,
        output moveFrame, X_direction, toggleY, moverResetN, lives, state
    );
endinterface

// File: rtl/motion_sequencer.sv
// Game flow sequencer: serve, run, bounce holdoff, lives and game over.
// Define PAUSE_EN to build the PAUSE state and pauseKey handling.
module motion_sequencer #(
    parameter int LIVES          = 3,
    parameter int LAUNCH_FRAMES  = 30,
    parameter int HOLDOFF_FRAMES = 4
) (
    input  logic                clk,
    input  logic                resetN,
    motion_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        RUN       = 3'd2,
        PAUSE     = 3'd3,
        LOST      = 3'd4,
        GAME_OVER = 3'd5
    } state_e;

    localparam logic [7:0] LAUNCH_LAST = 8'(LAUNCH_FRAMES - 1);
    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [3:0] HOLD_INIT   = 4'(HOLDOFF_FRAMES);

    state_e     state_q, state_d;
    logic       start_q, coll_q;
    logic [1:0] lives_q, lives_d;
    logic       xdir_q, xdir_d;
    logic       toggle_q, toggle_d;
    logic       mvr_q, mvr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic       start_edge, coll_edge, pause_edge;
    logic       bounce, move_frame;

    assign start_edge = bus.startKey & ~start_q;
    assign coll_edge  = bus.collision & ~coll_q;

`ifdef PAUSE_EN
    logic pause_q;

    assign pause_edge = bus.pauseKey & ~pause_q;

    // Previous pauseKey level for edge detection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) pause_q <= 1'b0;
        else         pause_q <= bus.pauseKey;
    end
`else
    logic unused_pause;

    assign unused_pause = bus.pauseKey;
    assign pause_edge   = 1'b0;
`endif

    // A bounce needs a fresh collision, no holdoff, and nothing of
    // higher priority (bottom hit, pause) in the same cycle.
    assign bounce = (state_q == RUN) & ~bus.bottomHit & ~pause_edge
                  & coll_edge & (hold_q == 4'd0);

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; unused codes fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_edge) state_d = LAUNCH;
            LAUNCH: begin
                if (bus.startOfFrame && cnt_q == LAUNCH_LAST)
                    state_d = RUN;
            end
            RUN: begin
                if (bus.bottomHit)
                    state_d = LOST;
`ifdef PAUSE_EN
                else if (pause_edge)
                    state_d = PAUSE;
`endif
            end
`ifdef PAUSE_EN
            PAUSE:     if (pause_edge) state_d = RUN;
`endif
            LOST: begin
                if (lives_q == 2'd1) state_d = GAME_OVER;
                else                 state_d = LAUNCH;
            end
            GAME_OVER: if (start_edge) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: motion frames pass straight through only in RUN
    always_comb begin
        move_frame = (state_q == RUN) & bus.startOfFrame;
    end

    // Datapath next values: lives, direction, pulses, counters
    always_comb begin
        lives_d  = lives_q;
        xdir_d   = xdir_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        toggle_d = 1'b0;
        mvr_d    = 1'b1;
        if (bus.startOfFrame && hold_q != 4'd0 && state_q != PAUSE)
            hold_d = hold_q - 4'd1;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    lives_d = LIVES_INIT;
                    mvr_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            LAUNCH: begin
                if (bus.startOfFrame) cnt_d = cnt_q + 8'd1;
            end
            RUN: begin
                if (bounce) begin
                    toggle_d = 1'b1;
                    hold_d   = HOLD_INIT;
                end
            end
            LOST: begin
                lives_d = lives_q - 2'd1;
                if (lives_q != 2'd1) begin
                    xdir_d = ~xdir_q;
                    mvr_d  = 1'b0;
                    cnt_d  = 8'd0;
                end
            end
            GAME_OVER: lives_d = 2'd0;
            default: ;
        endcase
    end

    // Datapath registers and input edge-detect history
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_q  <= 1'b0;
            coll_q   <= 1'b0;
            lives_q  <= 2'd0;
            xdir_q   <= 1'b1;
            toggle_q <= 1'b0;
            mvr_q    <= 1'b1;
            cnt_q    <= 8'd0;
            hold_q   <= 4'd0;
        end else begin
            start_q  <= bus.startKey;
            coll_q   <= bus.collision;
            lives_q  <= lives_d;
            xdir_q   <= xdir_d;
            toggle_q <= toggle_d;
            mvr_q    <= mvr_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.moveFrame   = move_frame;
    assign bus.X_direction = xdir_q;
    assign bus.toggleY     = toggle_q;
    assign bus.moverResetN = mvr_q;
    assign bus.lives       = lives_q;
    assign bus.state       = state_q;
endmodule
